// File: rtl/icache_pkg.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | icache_pkg                                                               |
// | Shared constants, controller state type and address-field helpers for    |
// | the direct-mapped instruction-cache controller.                          |
// | Revision: 1.0                                                            |
// +--------------------------------------------------------------------------+
package icache_pkg;

  localparam int ADDR_W   = 32;
  localparam int INDEX_W  = 8;
  localparam int OFFSET_W = 4;
  localparam int TAG_W    = ADDR_W - INDEX_W - OFFSET_W;
  localparam int LINE_W   = 128;

  typedef enum logic [2:0] {
    INIT   = 3'd0,
    IDLE   = 3'd1,
    LOOKUP = 3'd2,
    MISS   = 3'd3,
    REFILL = 3'd4,
    WRITE  = 3'd5
  } icache_state_t;

  // Line index: the bits just above the 16-byte line offset.
  function automatic logic [INDEX_W-1:0] get_index(input logic [ADDR_W-1:0] addr);
    return addr[OFFSET_W +: INDEX_W];
  endfunction

  // Tag: everything above index and offset.
  function automatic logic [TAG_W-1:0] get_tag(input logic [ADDR_W-1:0] addr);
    return addr[ADDR_W-1 -: TAG_W];
  endfunction

  // Word within the 4-word line.
  function automatic logic [1:0] get_word(input logic [ADDR_W-1:0] addr);
    return addr[3:2];
  endfunction

endpackage
`default_nettype wire

// File: rtl/icache_ctrl.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | icache_ctrl                                                              |
// | Direct-mapped instruction-cache controller between the IF stage and the |
// | tag/data block RAMs (single-port, 1-cycle read, write-first).            |
// | Serves hits at one per cycle, refills misses as 4-word bursts, and       |
// | sweeps the tag array invalid after reset.                                |
// |                                                                          |
// | Ports                                                                    |
// |   clka, rstn            clock, asynchronous active-low reset             |
// |   req_*                 fetch request (valid/ready, word-aligned PC)     |
// |   resp_*                one-cycle instruction response, no back-pressure |
// |   mem_rd_*, mem_ret_*   line read request and 4-beat return burst        |
// |   bram_addr             shared tag/data RAM address                      |
// |   tag_*, data_*         RAM write enables, write data and read data      |
// | Revision: 1.0                                                            |
// +--------------------------------------------------------------------------+
module icache_ctrl
  import icache_pkg::*;
#(
  parameter int ADDR_WIDTH  = ADDR_W,
  parameter int INDEX_WIDTH = INDEX_W,
  parameter int TAG_WIDTH   = ADDR_WIDTH - INDEX_WIDTH - OFFSET_W
) (
  input  logic                    clka,
  input  logic                    rstn,
  input  logic                    req_valid,
  output logic                    req_ready,
  input  logic [ADDR_WIDTH-1:0]   req_addr,
  output logic                    resp_valid,
  output logic [31:0]             resp_inst,
  output logic                    mem_rd_req,
  output logic [ADDR_WIDTH-1:0]   mem_rd_addr,
  input  logic                    mem_rd_ready,
  input  logic                    mem_ret_valid,
  input  logic [31:0]             mem_ret_data,
  input  logic                    mem_ret_last,
  output logic [INDEX_WIDTH-1:0]  bram_addr,
  output logic                    tag_we,
  output logic [TAG_WIDTH:0]      tag_din,
  input  logic [TAG_WIDTH:0]      tag_dout,
  output logic                    data_we,
  output logic [LINE_W-1:0]       data_din,
  input  logic [LINE_W-1:0]       data_dout
);

  icache_state_t            state, state_nxt;
  logic [INDEX_WIDTH-1:0]   init_cnt;
  logic [ADDR_WIDTH-1:0]    addr_q;
  logic [1:0]               beat_cnt;
  logic [3:0][31:0]         line_buf;

  logic [TAG_WIDTH-1:0]     tag_q;
  logic [1:0]               word_q;
  logic                     hit;
  logic                     accept;

  assign tag_q  = get_tag(addr_q);
  assign word_q = get_word(addr_q);
  assign hit    = tag_dout[TAG_WIDTH] && (tag_dout[TAG_WIDTH-1:0] == tag_q);
  assign accept = req_valid && req_ready;

  // Line-aligned refill address; only meaningful while in MISS, but kept
  // stable from the latched request so it never glitches during the wait.
  assign mem_rd_addr = {addr_q[ADDR_WIDTH-1:OFFSET_W], {OFFSET_W{1'b0}}};

  always_ff @(posedge clka or negedge rstn) begin
    if (!rstn) begin
      state    <= INIT;
      init_cnt <= '0;
      addr_q   <= '0;
      beat_cnt <= '0;
      line_buf <= '0;
    end else begin
      state <= state_nxt;
      if (state == INIT) begin
        init_cnt <= init_cnt + {{(INDEX_WIDTH-1){1'b0}}, 1'b1};
      end
      if (accept) begin
        addr_q <= req_addr;
      end
      // Beat counter restarts for every refill; an early mem_ret_last leaves
      // the remaining buffer words stale by design.
      if (state == MISS) begin
        beat_cnt <= '0;
      end else if (state == REFILL && mem_ret_valid) begin
        line_buf[beat_cnt] <= mem_ret_data;
        beat_cnt           <= beat_cnt + 2'd1;
      end
    end
  end

  always_comb begin
    state_nxt  = state;
    req_ready  = 1'b0;
    resp_valid = 1'b0;
    resp_inst  = '0;
    mem_rd_req = 1'b0;
    bram_addr  = '0;
    tag_we     = 1'b0;
    tag_din    = '0;
    data_we    = 1'b0;
    data_din   = '0;

    unique case (state)
      INIT: begin
        tag_we    = 1'b1;
        bram_addr = init_cnt;
        if (init_cnt == {INDEX_WIDTH{1'b1}}) begin
          state_nxt = IDLE;
        end
      end

      IDLE: begin
        req_ready = 1'b1;
        bram_addr = get_index(req_addr);
        if (req_valid) begin
          state_nxt = LOOKUP;
        end
      end

      LOOKUP: begin
        if (hit) begin
          resp_valid = 1'b1;
          resp_inst  = data_dout[{word_q, 5'b0} +: 32];
          // Pipelined hit: the next request's RAM read overlaps this response.
          req_ready  = 1'b1;
          bram_addr  = get_index(req_addr);
          state_nxt  = req_valid ? LOOKUP : IDLE;
        end else begin
          state_nxt = MISS;
        end
      end

      MISS: begin
        mem_rd_req = 1'b1;
        if (mem_rd_ready) begin
          state_nxt = REFILL;
        end
      end

      REFILL: begin
        if (mem_ret_valid && mem_ret_last) begin
          state_nxt = WRITE;
        end
      end

      WRITE: begin
        bram_addr  = get_index(addr_q);
        tag_we     = 1'b1;
        data_we    = 1'b1;
        tag_din    = {1'b1, tag_q};
        data_din   = line_buf;
        // Forward the missed word straight from the buffer.
        resp_valid = 1'b1;
        resp_inst  = line_buf[word_q];
        state_nxt  = IDLE;
      end

      default: begin
        state_nxt = INIT;
      end
    endcase
  end

endmodule
`default_nettype wire

// File: tb/tb_icache_ctrl.sv
`timescale 1ns/1ps
`default_nettype none
// +--------------------------------------------------------------------------+
// | tb_icache_ctrl                                                           |
// | Self-checking bench: behavioural tag/data RAMs and memory responder, a   |
// | reference cache model predicting hit/miss and the fetched word, and a    |
// | scoreboard monitor comparing every response and line write.              |
// | Revision: 1.0                                                            |
// +--------------------------------------------------------------------------+
module tb_icache_ctrl;

  localparam int AW = 32;
  localparam int IW = 8;
  localparam int TW = AW - IW - 4;

  logic          clka = 1'b0;
  logic          rstn = 1'b0;
  logic          req_valid = 1'b0;
  logic          req_ready;
  logic [AW-1:0] req_addr = '0;
  logic          resp_valid;
  logic [31:0]   resp_inst;
  logic          mem_rd_req;
  logic [AW-1:0] mem_rd_addr;
  logic          mem_rd_ready = 1'b0;
  logic          mem_ret_valid = 1'b0;
  logic [31:0]   mem_ret_data = '0;
  logic          mem_ret_last = 1'b0;
  logic [IW-1:0] bram_addr;
  logic          tag_we;
  logic [TW:0]   tag_din;
  logic [TW:0]   tag_dout;
  logic          data_we;
  logic [127:0]  data_din;
  logic [127:0]  data_dout;

  always #5 clka = ~clka;

  icache_ctrl dut (
    .clka          (clka),
    .rstn          (rstn),
    .req_valid     (req_valid),
    .req_ready     (req_ready),
    .req_addr      (req_addr),
    .resp_valid    (resp_valid),
    .resp_inst     (resp_inst),
    .mem_rd_req    (mem_rd_req),
    .mem_rd_addr   (mem_rd_addr),
    .mem_rd_ready  (mem_rd_ready),
    .mem_ret_valid (mem_ret_valid),
    .mem_ret_data  (mem_ret_data),
    .mem_ret_last  (mem_ret_last),
    .bram_addr     (bram_addr),
    .tag_we        (tag_we),
    .tag_din       (tag_din),
    .tag_dout      (tag_dout),
    .data_we       (data_we),
    .data_din      (data_din),
    .data_dout     (data_dout)
  );

  // ---------------- block RAMs (write-first, 1-cycle read) ----------------
  // Never-written entries read back as a valid tag 0x1C000 so a skipped
  // invalidation sweep turns the first cold miss into a false hit.
  logic [TW:0]  tag_mem  [256];
  logic [127:0] data_mem [256];
  bit           tag_wr   [256];
  bit           data_wr  [256];

  always @(posedge clka) begin
    if (tag_we) begin
      tag_mem[bram_addr] <= tag_din;
      tag_wr[bram_addr]  <= 1'b1;
    end
    tag_dout <= tag_we ? tag_din :
                (tag_wr[bram_addr] ? tag_mem[bram_addr] : {1'b1, 20'h1C000});
    if (data_we) begin
      data_mem[bram_addr] <= data_din;
      data_wr[bram_addr]  <= 1'b1;
    end
    data_dout <= data_we ? data_din :
                 (data_wr[bram_addr] ? data_mem[bram_addr] : {4{32'hDEADBEEF}});
  end

  int cyc = 0;
  always @(posedge clka) cyc <= cyc + 1;

  // ---------------- checking bookkeeping ----------------
  int n_checks = 0;
  int n_pass   = 0;

  task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %h required %h", name, act, exp);
  endtask

  task automatic fail_now(input string name);
    n_checks++;
    $display("FAIL %s: event missing or unexpected (got other, required expected)", name);
  endtask

  // Main memory contents seen by the cache: the line at 0x1C000010 holds
  // 0xA0..0xA3, everything else a per-address hash.
  function automatic logic [31:0] mem_word(input logic [31:0] a);
    logic [31:0] w;
    w = a & 32'hFFFF_FFFC;
    if (a[31:4] == 28'h1C00001) return 32'hA0 + 32'(a[3:2]);
    return (w * 32'h9E37_79B1) ^ 32'h5A5A_1234;
  endfunction

  typedef struct {
    logic [31:0] inst;
    bit          hit;
    int          cyc;
  } exp_t;

  exp_t        exp_q[$];
  logic [31:0] mem_q[$];
  logic [TW:0] model_tag [256];

  // Reference model: a direct-mapped tag table; a request hits only if its
  // line was the last one fetched into that index since reset.
  task automatic accept_model(input logic [31:0] a);
    exp_t e;
    logic [7:0]    idx;
    logic [TW-1:0] tg;
    idx    = a[11:4];
    tg     = a[31:12];
    e.inst = mem_word(a);
    e.cyc  = cyc;
    e.hit  = (model_tag[idx] == {1'b1, tg});
    if (!e.hit) begin
      mem_q.push_back({a[31:4], 4'b0});
      model_tag[idx] = {1'b1, tg};
    end
    exp_q.push_back(e);
  endtask

  task automatic model_reset();
    for (int i = 0; i < 256; i++) model_tag[i] = '0;
    exp_q.delete();
    mem_q.delete();
  endtask

  // ---------------- scoreboard monitor ----------------
  exp_t        mon_e;
  logic [31:0] wr_line = '0;

  always @(negedge clka) begin
    if (rstn && resp_valid) begin
      if (exp_q.size() == 0) begin
        fail_now("unexpected_resp");
      end else begin
        mon_e = exp_q.pop_front();
        chk("resp_inst", resp_inst, mon_e.inst);
        if (mon_e.hit) chk("hit_latency", cyc, mon_e.cyc + 1);
        else           chk("miss_latency_after_lookup", cyc > mon_e.cyc + 1, 1);
      end
    end
    if (rstn && data_we) begin
      chk("write_tag", {tag_we, bram_addr, tag_din},
          {1'b1, wr_line[11:4], 1'b1, wr_line[31:12]});
      chk("write_line", data_din,
          {mem_word(wr_line + 12), mem_word(wr_line + 8),
           mem_word(wr_line + 4), mem_word(wr_line)});
    end
  end

  // ---------------- memory responder ----------------
  int force_delay = -1;
  int beat_limit  = 1 << 30;
  int beats_sent  = 0;

  task automatic mem_idle();
    mem_rd_ready  = 1'b0;
    mem_ret_valid = 1'b0;
    mem_ret_last  = 1'b0;
    mem_ret_data  = '0;
  endtask

  task automatic serve();
    logic [31:0] a;
    int          d;
    int          gap;
    bit          hold_ok;
    a       = mem_rd_addr;
    wr_line = a;
    if (mem_q.size() == 0) fail_now("unexpected_mem_rd_req");
    else chk("mem_rd_addr", a, mem_q.pop_front());
    d       = (force_delay >= 0) ? force_delay : int'($urandom_range(0, 3));
    hold_ok = 1'b1;
    // Ready held low; stray return beats must be ignored while in MISS.
    for (int i = 0; i < d; i++) begin
      @(posedge clka); #1;
      if (!rstn) begin mem_idle(); return; end
      mem_rd_ready  = 1'b0;
      mem_ret_valid = 1'($urandom_range(0, 1));
      mem_ret_data  = $urandom;
      mem_ret_last  = 1'($urandom_range(0, 1));
      @(negedge clka);
      if (!(mem_rd_req === 1'b1 && mem_rd_addr === a)) hold_ok = 1'b0;
    end
    if (d > 0) chk("miss_hold_stable", hold_ok, 1);
    @(posedge clka); #1;
    if (!rstn) begin mem_idle(); return; end
    mem_ret_valid = 1'b0;
    mem_ret_last  = 1'b0;
    mem_rd_ready  = 1'b1;
    @(posedge clka); #1;
    mem_rd_ready = 1'b0;
    for (int b = 0; b < 4; b++) begin
      if (!rstn) begin mem_idle(); return; end
      if (beats_sent >= beat_limit) begin
        for (int t = 0; t < 100 && rstn; t++) @(posedge clka);
        mem_idle();
        return;
      end
      mem_ret_valid = 1'b1;
      mem_ret_data  = mem_word(a + 32'(4 * b));
      mem_ret_last  = (b == 3);
      beats_sent++;
      @(posedge clka); #1;
      mem_ret_valid = 1'b0;
      mem_ret_last  = 1'b0;
      if (b < 3) begin
        gap = $urandom_range(0, 1);
        for (int g = 0; g < gap; g++) begin @(posedge clka); #1; end
      end
    end
  endtask

  initial begin : responder
    forever begin
      @(negedge clka);
      if (rstn && mem_rd_req) serve();
    end
  end

  // ---------------- stimulus ----------------
  task automatic issue(input logic [31:0] a);
    int guard;
    guard     = 0;
    req_valid = 1'b1;
    req_addr  = a;
    forever begin
      @(negedge clka);
      if (req_ready === 1'b1) begin
        accept_model(a);
        @(posedge clka); #1;
        return;
      end
      @(posedge clka); #1;
      guard++;
      if (guard > 300) begin fail_now("accept_timeout"); return; end
    end
  endtask

  task automatic idle(input int n);
    req_valid = 1'b0;
    repeat (n) begin @(posedge clka); #1; end
  endtask

  task automatic drain();
    int guard;
    guard     = 0;
    req_valid = 1'b0;
    while ((exp_q.size() != 0 || mem_q.size() != 0) && guard < 500) begin
      @(posedge clka); #1;
      guard++;
    end
    if (guard >= 500) begin
      fail_now("drain_timeout");
      exp_q.delete();
      mem_q.delete();
    end
    repeat (2) begin @(posedge clka); #1; end
  endtask

  task automatic check_reset_outputs(input string name);
    @(negedge clka);
    chk({name, "_ctrl"}, {req_ready, resp_valid, mem_rd_req, tag_we, data_we}, 5'b00010);
    chk({name, "_data"}, {bram_addr, tag_din, mem_rd_addr, resp_inst}, '0);
    chk({name, "_line"}, data_din, '0);
  endtask

  task automatic check_init();
    bit ok;
    ok = 1'b1;
    for (int i = 0; i < 256; i++) begin
      @(negedge clka);
      if (!(req_ready === 1'b0 && tag_we === 1'b1 && data_we === 1'b0 &&
            tag_din === '0 && bram_addr === 8'(i))) ok = 1'b0;
    end
    chk("init_sweep_256", ok, 1);
    @(negedge clka);
    chk("ready_after_init", {req_ready, tag_we}, 2'b10);
    @(posedge clka); #1;
  endtask

  logic [19:0] tag_pool [3];

  initial begin : main
    tag_pool[0] = 20'h1C000;
    tag_pool[1] = 20'h1C001;
    tag_pool[2] = 20'h00ABC;
    model_reset();
    mem_idle();

    check_reset_outputs("reset_vals");
    @(posedge clka); #1;
    rstn = 1'b1;
    check_init();

    // Cold miss, word 2 of the 0xA0.. line.
    issue(32'h1C000018);
    drain();

    // Back-to-back hits on the same line.
    issue(32'h1C000010);
    issue(32'h1C000014);
    issue(32'h1C00001C);
    drain();

    // Conflict miss on index 1, then the evicted line misses again.
    issue(32'h1C001010);
    drain();
    issue(32'h1C000010);
    drain();

    // Slow memory handshake with stray beats during MISS.
    force_delay = 5;
    issue(32'h00ABC020);
    drain();
    force_delay = -1;

    // Randomized mix of hits, cold and conflict misses.
    for (int n = 0; n < 80; n++) begin
      issue({tag_pool[$urandom_range(0, 2)], 8'($urandom_range(0, 3)),
             2'($urandom_range(0, 3)), 2'b00});
      if ($urandom_range(0, 2) == 0) idle($urandom_range(0, 2));
    end
    drain();

    // Reset in the middle of a refill, after two beats.
    beats_sent = 0;
    beat_limit = 2;
    issue(32'h0DEF0044);
    idle(0);
    begin
      int guard;
      guard = 0;
      while (beats_sent < 2 && guard < 200) begin @(negedge clka); guard++; end
      if (guard >= 200) fail_now("refill_beats_timeout");
    end
    @(posedge clka); #1;
    rstn = 1'b0;
    check_reset_outputs("reset_mid_refill");
    model_reset();
    beat_limit = 1 << 30;
    @(posedge clka); #1;
    rstn = 1'b1;
    check_init();

    // Same line after the aborted refill must miss again.
    issue(32'h0DEF0044);
    drain();

    chk("resp_queue_empty", exp_q.size(), 0);
    chk("mem_queue_empty", mem_q.size(), 0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

  initial begin : watchdog
    #500000;
    $display("FAIL watchdog: simulation still running (got timeout, required finish)");
    $fatal(1, "watchdog expired");
  end

endmodule
`default_nettype wire
